// File: rtl/serial_shares_pkg.sv
// Shared definitions for the serial masked-datapath input stage.
// Holds the deserializer FSM encoding and the parallel bus width helper.
// Ports: none (package only).
package serial_shares_pkg;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_FULL    = 1'b1
   } state_t;

   // Width of the assembled shared bus: every share carries the full slot count.
   function automatic int bus_bits(input int n_shares, input int words_per_share, input int word_bits);
      return n_shares * words_per_share * word_bits;
   endfunction

endpackage

// File: rtl/serial_shares_deserializer_if.sv
// Handshake bundle between the serial producer, the deserializer and the core.
// Serial side: in_data/in_valid/in_ready; parallel side: out_data/out_valid/out_ready.
// Ports: master = producer + consumer side (testbench/system), slave = deserializer.
interface serial_shares_deserializer_if #(
   parameter int d                   = 2,
   parameter int WORD_BITS           = 32,
   parameter int MAX_WORDS_PER_SHARE = 8
);
   import serial_shares_pkg::*;

   localparam int BUS_BITS = bus_bits(d, MAX_WORDS_PER_SHARE, WORD_BITS);

   logic [WORD_BITS-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [BUS_BITS-1:0]  out_data;
   logic                 out_valid;
   logic                 out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );

endinterface

// File: rtl/serial_shares_words_counter.sv
// Share-major slot address generator: word index runs 0..bound, then share advances.
// Latency: indices update on the edge that sees i_inc; no backpressure (advances on every i_inc).
// Ports: i_clk, i_rst (sync, active-high), i_inc, i_bound -> o_share_idx, o_word_idx.
module serial_shares_words_counter #(
   parameter int NBITS               = 4,
   parameter int MAX_WORDS_PER_SHARE = 8,
   parameter int d                   = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_inc,
   input  logic [NBITS-1:0] i_bound,
   output logic [NBITS-1:0] o_share_idx,
   output logic [NBITS-1:0] o_word_idx
);

   logic [NBITS-1:0] r_share_idx;
   logic [NBITS-1:0] r_word_idx;
   logic             w_word_wrap;
   logic             w_share_wrap;

   // Wrapping at the last physical slot keeps an illegal bound from walking past the bus.
   assign w_word_wrap  = (r_word_idx == i_bound) || (r_word_idx == NBITS'(MAX_WORDS_PER_SHARE - 1));
   assign w_share_wrap = (r_share_idx == NBITS'(d - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_share_idx <= '0;
         r_word_idx  <= '0;
      end else if (i_inc) begin
         if (w_word_wrap) begin
            r_word_idx  <= '0;
            r_share_idx <= w_share_wrap ? '0 : r_share_idx + 1'b1;
         end else begin
            r_word_idx  <= r_word_idx + 1'b1;
         end
      end
   end

   assign o_share_idx = r_share_idx;
   assign o_word_idx  = r_word_idx;

endmodule

// File: rtl/serial_shares_deserializer.sv
// Collects d shares of serial words (share-major) into one parallel shared frame.
// Latency: out_valid rises the cycle after the last word is accepted.
// Backpressure: frame held, in_ready low until out_ready; release clears all slots.
// Ports: i_clk, i_rst (sync, active-high), i_words_per_share_bound, bus (slave modport).
module serial_shares_deserializer
   import serial_shares_pkg::*;
#(
   parameter int d                   = 2,
   parameter int WORD_BITS           = 32,
   parameter int MAX_WORDS_PER_SHARE = 8,
   parameter int NBITS               = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NBITS-1:0]              i_words_per_share_bound,
   serial_shares_deserializer_if.slave   bus
);

   localparam int BUS_BITS = bus_bits(d, MAX_WORDS_PER_SHARE, WORD_BITS);

   state_t              r_state;
   logic                r_in_ready;
   logic                r_out_valid;
   logic [BUS_BITS-1:0] r_data;

   logic [NBITS-1:0]    w_share_idx;
   logic [NBITS-1:0]    w_word_idx;
   logic                w_accept;
   logic                w_last;
   logic                w_release;
   logic                w_cnt_rst;

   assign w_accept  = bus.in_valid & r_in_ready;
   assign w_last    = (w_share_idx == NBITS'(d - 1)) && (w_word_idx == i_words_per_share_bound);
   assign w_release = r_out_valid & bus.out_ready;
   assign w_cnt_rst = i_rst | w_release;

   serial_shares_words_counter #(
      .NBITS               (NBITS),
      .MAX_WORDS_PER_SHARE (MAX_WORDS_PER_SHARE),
      .d                   (d)
   ) u_counter (
      .i_clk       (i_clk),
      .i_rst       (w_cnt_rst),
      .i_inc       (w_accept),
      .i_bound     (i_words_per_share_bound),
      .o_share_idx (w_share_idx),
      .o_word_idx  (w_word_idx)
   );

   // Handshake flags are registered alongside the state so neither depends on in_valid/out_ready.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_COLLECT;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_COLLECT: begin
               if (w_accept && w_last) begin
                  r_state     <= ST_FULL;
                  r_in_ready  <= 1'b0;
                  r_out_valid <= 1'b1;
               end
            end
            ST_FULL: begin
               if (bus.out_ready) begin
                  r_state     <= ST_COLLECT;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_COLLECT;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Slots are wiped on every frame hand-off so no share material survives into the next frame.
   always_ff @(posedge i_clk) begin
      if (i_rst || w_release) begin
         r_data <= '0;
      end else if (w_accept) begin
         for (int s = 0; s < d; s++) begin
            for (int w = 0; w < MAX_WORDS_PER_SHARE; w++) begin
               if ((w_share_idx == NBITS'(s)) && (w_word_idx == NBITS'(w))) begin
                  r_data[((s * MAX_WORDS_PER_SHARE) + w) * WORD_BITS +: WORD_BITS] <= bus.in_data;
               end
            end
         end
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_data;

endmodule

// File: tb/tb_serial_shares_deserializer.sv
module tb_serial_shares_deserializer;

   localparam int D     = 2;
   localparam int WB    = 32;
   localparam int MW    = 8;
   localparam int NB    = 4;
   localparam int BUSW  = D * MW * WB;

   logic          clk;
   logic          rst;
   logic [NB-1:0] bound;

   int checks;
   int errors;

   serial_shares_deserializer_if #(.d(D), .WORD_BITS(WB), .MAX_WORDS_PER_SHARE(MW)) bus ();

   serial_shares_deserializer #(
      .d                   (D),
      .WORD_BITS           (WB),
      .MAX_WORDS_PER_SHARE (MW),
      .NBITS               (NB)
   ) dut (
      .i_clk                   (clk),
      .i_rst                   (rst),
      .i_words_per_share_bound (bound),
      .bus                     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [BUSW-1:0] place(input logic [BUSW-1:0] acc, input int s, input int w,
                                             input logic [WB-1:0] val);
      logic [BUSW-1:0] r;
      r = acc;
      r[((s * MW) + w) * WB +: WB] = val;
      return r;
   endfunction

   task automatic release_frame();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bound         = 4'd3;
      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
      checks++;
      if (bus.out_data !== '0) begin
         errors++; $display("FAIL reset_out_data: got %h want 0", bus.out_data);
      end
   endtask

   logic [BUSW-1:0] basic_exp;

   task automatic test_basic();
      logic [WB-1:0] wv;
      bound     = 4'd3;
      basic_exp = '0;
      for (int i = 0; i < 8; i++) begin
         wv = 32'h1111_1111 * (i + 1);
         basic_exp = place(basic_exp, i / 4, i % 4, wv);
         checks++;
         if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept_%0d: in_ready=%b out_valid=%b want 1/0", i, bus.in_ready, bus.out_valid);
         end
         bus.in_data  = wv;
         bus.in_valid = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_complete: out_valid=%b in_ready=%b want 1/0", bus.out_valid, bus.in_ready);
      end
      checks++;
      if (bus.out_data !== basic_exp) begin
         errors++; $display("FAIL basic_data: got %h want %h", bus.out_data, basic_exp);
      end
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 32'hDEAD_BE00 | c;
         tick();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== basic_exp) begin
            errors++;
            $display("FAIL hold_cycle_%0d: out_valid=%b in_ready=%b data=%h want 1/0/%h",
                     c, bus.out_valid, bus.in_ready, bus.out_data, basic_exp);
         end
      end
      release_frame();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_flags: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
      end
      checks++;
      if (bus.out_data !== '0) begin
         errors++; $display("FAIL release_clear: got %h want 0", bus.out_data);
      end
   endtask

   task automatic test_bound0();
      logic [BUSW-1:0] exp;
      bound = 4'd0;
      exp   = '0;
      exp   = place(exp, 0, 0, 32'hA5A5_A5A5);
      exp   = place(exp, 1, 0, 32'h5A5A_5A5A);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hA5A5_A5A5;
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b0_after_first: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
      end
      bus.in_data = 32'h5A5A_5A5A;
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL b0_complete: out_valid=%b want 1", bus.out_valid);
      end
      checks++;
      if (bus.out_data !== exp) begin
         errors++; $display("FAIL b0_data: got %h want %h", bus.out_data, exp);
      end
      release_frame();
   endtask

   task automatic test_random_gaps();
      logic [BUSW-1:0] exp;
      int idx;
      int budget;
      int early;
      bit v;
      bound  = 4'd7;
      exp    = '0;
      idx    = 0;
      budget = 400;
      early  = 0;
      while (idx < 16 && budget > 0) begin
         v = 1'($urandom_range(0, 1));
         bus.in_valid = v;
         bus.in_data  = 32'hC0DE_0000 | idx;
         tick();
         if (v) begin
            exp = place(exp, idx / 8, idx % 8, 32'hC0DE_0000 | idx);
            idx++;
         end
         if (idx < 16 && bus.out_valid !== 1'b0) early++;
         budget--;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (idx != 16) begin
         errors++; $display("FAIL gaps_timeout: accepted %0d want 16", idx);
      end
      checks++;
      if (early != 0) begin
         errors++; $display("FAIL gaps_early_valid: %0d cycles want 0", early);
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
         errors++;
         $display("FAIL gaps_frame: out_valid=%b data=%h want 1/%h", bus.out_valid, bus.out_data, exp);
      end
      release_frame();
   endtask

   task automatic test_rst_midframe();
      logic [BUSW-1:0] exp;
      bound = 4'd3;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 32'hBAD0_0000 | i;
         tick();
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (bus.out_data !== '0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_state: data=%h in_ready=%b out_valid=%b want 0/1/0",
                  bus.out_data, bus.in_ready, bus.out_valid);
      end
      exp = '0;
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 32'h6000_0000 | (i << 4);
         exp = place(exp, i / 4, i % 4, 32'h6000_0000 | (i << 4));
         tick();
      end
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
         errors++;
         $display("FAIL midrst_frame: out_valid=%b data=%h want 1/%h", bus.out_valid, bus.out_data, exp);
      end
      release_frame();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_backpressure();
      test_bound0();
      test_random_gaps();
      test_rst_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/serial_shares_deserializer.md
# serial_shares_deserializer

Input stage of the 32-bit serial masked datapath. Accepts shared data one word per handshake in share-major order (all words of share 0, then share 1, …, share d-1) and assembles them into a parallel shared bus. Slot addressing comes from an embedded `serial_shares_words_counter`. Once the frame is complete, the block presents it to the downstream core under a valid/ready handshake.

## Interface
Parameters:
- `d`, 2: number of shares.
- `WORD_BITS`, 32: bits per serial word.
- `MAX_WORDS_PER_SHARE`, 8: word slots per share in the output bus.
- `NBITS`, 4: counter width; must satisfy 2^NBITS > max(d, MAX_WORDS_PER_SHARE).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous active-high reset.
- `words_per_share_bound`  in  NBITS  words per share minus one; legal range 0..MAX_WORDS_PER_SHARE-1; stable from first word of a frame until its output handshake.
- `in_data`  in  WORD_BITS  serial word.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block accepts a word this cycle.
- `out_data`  out  d*MAX_WORDS_PER_SHARE*WORD_BITS  assembled frame; word w of share s at bits [((s*MAX_WORDS_PER_SHARE)+w)*WORD_BITS +: WORD_BITS].
- `out_valid`  out  1  frame complete.
- `out_ready`  in  1  downstream consumes frame.

## Operation
- FSM states: COLLECT, FULL. Reset state is COLLECT.
- `in_ready` = (state==COLLECT); `out_valid` = (state==FULL). Both are pure state decodes, with no combinational path from `in_valid` or `out_ready`.
- COLLECT, on in_valid & in_ready:
  - write `in_data` into slot (share_idx, word_idx);
  - pulse counter `inc`.
- Last word is share_idx==d-1 and word_idx==words_per_share_bound. Accepting it moves the FSM to FULL.
- FULL: `in_data`/`in_valid` are ignored. On out_ready:
  - FSM returns to COLLECT;
  - all data slots clear to zero (no share residue is left across frames);
  - counter resets.
- Counter `rst` = rst | (FULL & out_ready). Counter `inc` = in_valid & in_ready.
- Slots with word index > words_per_share_bound are never written and read zero.
- An illegal bound (≥ MAX_WORDS_PER_SHARE) is unsupported; writes to out-of-range slots are dropped. The bench does not check further.

## Timing
- Reset values: state=COLLECT, out_valid=0, in_ready=1 from the first cycle after rst deasserts, all out_data bits 0, counter 0/0.
- At most one word per cycle. A frame of N=d*(bound+1) words takes N accepting cycles.
- Completion latency: last word accepted at edge t, out_valid=1 from t (visible the cycle after the handshake cycle).
- out_valid stays high and out_data is held stable until out_ready. in_ready=0 throughout.
- Output handshake at edge t: out_valid=0 and in_ready=1 from t. The next frame's first word can be accepted in the following cycle, giving a minimum one-cycle bubble per frame.
- rst mid-frame: partial data discarded, slots zeroed, counter cleared, FSM back to COLLECT on the next edge. rst has priority over every handshake.
- bound=0: one word per share; the share index advances on every accepted word.

## Structure
- Shared package `serial_shares_pkg`:
  - FSM state encoding (COLLECT=0, FULL=1);
  - helper constant for bus width d*MAX_WORDS_PER_SHARE*WORD_BITS.
- Sub-module: one `serial_shares_words_counter` instance (parameters NBITS, MAX_WORDS_PER_SHARE, d passed through). It provides share_idx/word_idx for slot decode.
- Data storage: d*MAX_WORDS_PER_SHARE word registers. Per-slot write enable = accept & (share_idx==s) & (word_idx==w). Clear on rst or output handshake.

## Test plan
- Reset: assert rst 2 cycles, then release. Require out_valid=0, in_ready=1, out_data all zero.
- d=2, bound=3, words 0x11111111..0x88888888 with in_valid held high:
  - in_ready high for 8 accepts, then out_valid=1;
  - share0 slots 0..3 = 0x1111_1111..0x4444_4444, share1 slots 0..3 = 0x5555_5555..0x8888_8888, slots 4..7 = 0.
- Backpressure: hold out_ready=0 for 10 cycles after completion.
  - out_data stable, in_ready=0, extra in_valid words ignored;
  - out_ready=1 → next cycle out_valid=0, out_data zero, in_ready=1.
- bound=0, d=2, words 0xA5A5A5A5, 0x5A5A5A5A → share0 w0=0xA5A5A5A5, share1 w0=0x5A5A5A5A, out_valid after 2 accepts.
- Random in_valid gaps (~50% duty), bound=7: the frame equals the accepted word sequence in order, and idle cycles never advance the counter.
- rst asserted after 3 of 8 words, then a full new frame is sent: the output contains only new-frame words, with no residue from the aborted words.
